fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_fetch_pkg.sv | 27 ++
 rtl/fetch_pc_mux.sv | 62 ++++++
 rtl/fetch_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared constants, the redirect-select encoding and address helpers for the
// MIPS fetch stage.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int unsigned IMEM_WORDS_DEFAULT = 32'd8192;
  localparam logic [31:0] NOP_WORD           = 32'h0000_0000;

  // Source of the next PC; SEQ covers both PC+4 and the stalled hold.
  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    JR     = 2'd3
  } redirect_sel_e;

  // True when a byte address does not sit on a word boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Clear the byte-offset bits so fetch always starts on a word.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_mux.sv
// Combinational next-PC selection: prioritised redirect sources, stall hold,
// and sequential PC+4 with natural 32-bit wrap.
module fetch_pc_mux
  import mips_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [25:0] jump_index,
  input  logic [3:0]  id_pc_hi,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        misaligned
);

  redirect_sel_e sel_s;
  logic [31:0]   target_s;

  assign pc_plus4 = pc + 32'd4;

  // Priority-encode the redirect source: branch, then jump, then jr.
  always_comb begin
    sel_s = SEQ;
    if (branch_valid) begin
      sel_s = BRANCH;
    end else if (jump_valid) begin
      sel_s = JUMP;
    end else if (jr_valid) begin
      sel_s = JR;
    end else begin
      sel_s = SEQ;
    end
  end

  // Form the raw target and pick the next PC; a redirect beats a stall.
  always_comb begin
    target_s = 32'h0000_0000;
    next_pc  = pc;
    case (sel_s)
      BRANCH:  target_s = branch_target;
      JUMP:    target_s = {id_pc_hi, jump_index, 2'b00};
      JR:      target_s = jr_target;
      default: target_s = 32'h0000_0000;
    endcase
    if (sel_s != SEQ) begin
      next_pc = word_align(target_s);
    end else if (stall) begin
      next_pc = pc;
    end else begin
      next_pc = pc_plus4;
    end
  end

  assign redirect   = (sel_s != SEQ);
  assign misaligned = redirect && is_misaligned(target_s);

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register and a
// one-cycle address-error pulse for misaligned redirects and fetches beyond
// the end of instruction memory.
module fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [25:0] jump_index,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_address,
  input  logic [31:0] ir,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        addr_err
);

  // One bit wider than the PC so a memory that spans the full space still compares correctly.
  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] pc_plus4_s;
  logic        redirect_s;
  logic        misaligned_s;
  logic        out_of_range_s;
  logic        oor_fetch_s;

  fetch_pc_mux u_pc_mux (
    .pc            (pc_q),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_index    (jump_index),
    .id_pc_hi      (id_pc_plus4_q[31:28]),
    .jr_valid      (jr_valid),
    .jr_target     (jr_target),
    .next_pc       (pc_d),
    .pc_plus4      (pc_plus4_s),
    .redirect      (redirect_s),
    .misaligned    (misaligned_s)
  );

  assign out_of_range_s = ({1'b0, pc_q} >= IMEM_LIMIT);

  // IF/ID update: squash on flush/redirect, hold on stall, else capture the fetch.
  always_comb begin
    id_instr_d    = id_instr_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    oor_fetch_s   = 1'b0;
    if (flush || redirect_s) begin
      id_instr_d    = NOP_WORD;
      id_pc_plus4_d = 32'h0000_0000;
      id_valid_d    = 1'b0;
    end else if (stall) begin
      id_instr_d    = id_instr_q;
      id_pc_plus4_d = id_pc_plus4_q;
      id_valid_d    = id_valid_q;
    end else if (out_of_range_s) begin
      // Whatever memory returns past its end is not a real instruction.
      id_instr_d    = NOP_WORD;
      id_pc_plus4_d = 32'h0000_0000;
      id_valid_d    = 1'b0;
      oor_fetch_s   = 1'b1;
    end else begin
      id_instr_d    = ir;
      id_pc_plus4_d = pc_plus4_s;
      id_valid_d    = 1'b1;
    end
    addr_err_d = oor_fetch_s || misaligned_s;
  end

  // PC, IF/ID and error flops with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= NOP_WORD;
      id_pc_plus4_q <= 32'h0000_0000;
      id_valid_q    <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign pc_address  = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;
  assign addr_err    = addr_err_q;

endmodule
